// File: rtl/pipeline_control_unit_pkg.sv
// Shared encodings for the pipeline control unit: PC-source select codes and CP0 ExcCode values.
package pipeline_control_unit_pkg;

  typedef enum logic [3:0] {
    PC_SEQ  = 4'd0,
    PC_JUMP = 4'd1,
    PC_JR   = 4'd2,
    PC_FIX  = 4'd3,
    PC_EXC  = 4'd4,
    PC_EPC  = 4'd5
  } pc_src_e;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

endpackage

// File: rtl/pipeline_control_unit.sv
// Hazard/exception controller: all decisions are combinational and take effect in the same cycle.
// A memory stall freezes every stage; an interrupt that arrives during the stall is held and serviced afterwards.
module pipeline_control_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_ir,
  input  logic        id_jump,
  input  logic        mem_stall,
  input  logic [4:0]  ifid_rs_addr,
  input  logic [4:0]  real_rt_addr,
  input  logic [4:0]  idex_rd_addr,
  input  logic        idex_mem_read,
  input  logic [31:0] predicted_idex_pc,
  input  logic [31:0] target_exmem_pc,
  input  logic        cp0_intr,
  input  logic        exmem_syscall,
  input  logic        exmem_eret,
  output logic [3:0]  cu_pc_src,
  output logic        cu_pc_stall,
  output logic        cu_ifid_stall,
  output logic        cu_idex_stall,
  output logic        cu_exmem_stall,
  output logic        cu_ifid_flush,
  output logic        cu_idex_flush,
  output logic        cu_exmem_flush,
  output logic        cu_cp0_w_en,
  output logic [4:0]  cu_exec_code,
  output logic [31:0] cu_epc,
  output logic [31:0] cu_vector,
  output logic        bpu_write_en
);

  logic intr_pending;
  logic intr_req;
  logic mispredict;
  logic load_use;
  logic intr_taken;

  assign intr_req   = cp0_intr | intr_pending;
  assign mispredict = predicted_idex_pc != target_exmem_pc;
  assign load_use   = idex_mem_read && (idex_rd_addr != 5'd0) &&
                      ((idex_rd_addr == ifid_rs_addr) || (idex_rd_addr == real_rt_addr));
  assign intr_taken = rst_n && !mem_stall && intr_req;

  assign cu_epc    = target_exmem_pc;
  assign cu_vector = EXC_VECTOR;

  always_comb begin
    cu_pc_src      = PC_SEQ;
    cu_pc_stall    = 1'b0;
    cu_ifid_stall  = 1'b0;
    cu_idex_stall  = 1'b0;
    cu_exmem_stall = 1'b0;
    cu_ifid_flush  = 1'b0;
    cu_idex_flush  = 1'b0;
    cu_exmem_flush = 1'b0;
    cu_cp0_w_en    = 1'b0;
    cu_exec_code   = EXC_INT;
    bpu_write_en   = 1'b0;
    if (!rst_n) begin
      // Keep every stage bubbled while reset is held.
      cu_ifid_flush  = 1'b1;
      cu_idex_flush  = 1'b1;
      cu_exmem_flush = 1'b1;
    end else if (mem_stall) begin
      cu_pc_stall    = 1'b1;
      cu_ifid_stall  = 1'b1;
      cu_idex_stall  = 1'b1;
      cu_exmem_stall = 1'b1;
    end else if (intr_req || exmem_syscall) begin
      cu_pc_src      = PC_EXC;
      cu_ifid_flush  = 1'b1;
      cu_idex_flush  = 1'b1;
      cu_exmem_flush = 1'b1;
      cu_cp0_w_en    = 1'b1;
      cu_exec_code   = intr_req ? EXC_INT : EXC_SYS;
    end else if (exmem_eret) begin
      cu_pc_src      = PC_EPC;
      cu_ifid_flush  = 1'b1;
      cu_idex_flush  = 1'b1;
      cu_exmem_flush = 1'b1;
    end else if (mispredict) begin
      cu_pc_src      = PC_FIX;
      cu_ifid_flush  = 1'b1;
      cu_idex_flush  = 1'b1;
      bpu_write_en   = 1'b1;
    end else if (load_use) begin
      // Jumps in ID wait until the load result is forwardable.
      cu_pc_stall    = 1'b1;
      cu_ifid_stall  = 1'b1;
      cu_idex_flush  = 1'b1;
    end else if (id_ir) begin
      cu_pc_src      = PC_JR;
      cu_ifid_flush  = 1'b1;
    end else if (id_jump) begin
      cu_pc_src      = PC_JUMP;
      cu_ifid_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intr_pending <= 1'b0;
    end else if (cp0_intr && mem_stall) begin
      intr_pending <= 1'b1;
    end else if (intr_taken) begin
      intr_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed and randomized checks of pipeline_control_unit against a priority-table reference model.
module tb_pipeline_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_ir, id_jump, mem_stall;
  logic [4:0]  ifid_rs_addr, real_rt_addr, idex_rd_addr;
  logic        idex_mem_read;
  logic [31:0] predicted_idex_pc, target_exmem_pc;
  logic        cp0_intr, exmem_syscall, exmem_eret;
  logic [3:0]  cu_pc_src;
  logic        cu_pc_stall, cu_ifid_stall, cu_idex_stall, cu_exmem_stall;
  logic        cu_ifid_flush, cu_idex_flush, cu_exmem_flush;
  logic        cu_cp0_w_en;
  logic [4:0]  cu_exec_code;
  logic [31:0] cu_epc, cu_vector;
  logic        bpu_write_en;

  int n_checks = 0;
  int n_fail   = 0;
  bit pend     = 1'b0;

  always #5 clk = ~clk;

  pipeline_control_unit dut (
    .clk(clk), .rst_n(rst_n), .id_ir(id_ir), .id_jump(id_jump), .mem_stall(mem_stall),
    .ifid_rs_addr(ifid_rs_addr), .real_rt_addr(real_rt_addr), .idex_rd_addr(idex_rd_addr),
    .idex_mem_read(idex_mem_read), .predicted_idex_pc(predicted_idex_pc),
    .target_exmem_pc(target_exmem_pc), .cp0_intr(cp0_intr), .exmem_syscall(exmem_syscall),
    .exmem_eret(exmem_eret), .cu_pc_src(cu_pc_src), .cu_pc_stall(cu_pc_stall),
    .cu_ifid_stall(cu_ifid_stall), .cu_idex_stall(cu_idex_stall), .cu_exmem_stall(cu_exmem_stall),
    .cu_ifid_flush(cu_ifid_flush), .cu_idex_flush(cu_idex_flush), .cu_exmem_flush(cu_exmem_flush),
    .cu_cp0_w_en(cu_cp0_w_en), .cu_exec_code(cu_exec_code), .cu_epc(cu_epc),
    .cu_vector(cu_vector), .bpu_write_en(bpu_write_en)
  );

  wire [17:0] ctrl_obs = {cu_pc_src, cu_pc_stall, cu_ifid_stall, cu_idex_stall, cu_exmem_stall,
                          cu_ifid_flush, cu_idex_flush, cu_exmem_flush, cu_cp0_w_en,
                          cu_exec_code, bpu_write_en};

  // Row number (1..9) of the first matching priority condition; 0 while in reset.
  function automatic int model_row();
    logic [9:1] hit;
    logic lu;
    if (!rst_n) return 0;
    lu = idex_mem_read && idex_rd_addr != 0 &&
         (idex_rd_addr == ifid_rs_addr || idex_rd_addr == real_rt_addr);
    hit = {1'b1, id_jump, id_ir, lu, predicted_idex_pc != target_exmem_pc,
           exmem_eret, exmem_syscall, cp0_intr | pend, mem_stall};
    for (int i = 1; i <= 9; i++) if (hit[i]) return i;
    return 9;
  endfunction

  // Expected {pc_src, stalls[4], flushes[3], cp0_w_en, exec_code, bpu} per row.
  function automatic logic [17:0] model_ctrl(input int row);
    case (row)
      0:       return {4'd0, 4'b0000, 3'b111, 1'b0, 5'd0, 1'b0};
      1:       return {4'd0, 4'b1111, 3'b000, 1'b0, 5'd0, 1'b0};
      2:       return {4'd4, 4'b0000, 3'b111, 1'b1, 5'd0, 1'b0};
      3:       return {4'd4, 4'b0000, 3'b111, 1'b1, 5'd8, 1'b0};
      4:       return {4'd5, 4'b0000, 3'b111, 1'b0, 5'd0, 1'b0};
      5:       return {4'd3, 4'b0000, 3'b110, 1'b0, 5'd0, 1'b1};
      6:       return {4'd0, 4'b1100, 3'b010, 1'b0, 5'd0, 1'b0};
      7:       return {4'd2, 4'b0000, 3'b100, 1'b0, 5'd0, 1'b0};
      8:       return {4'd1, 4'b0000, 3'b100, 1'b0, 5'd0, 1'b0};
      default: return {4'd0, 4'b0000, 3'b000, 1'b0, 5'd0, 1'b0};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    id_ir = 0; id_jump = 0; mem_stall = 0;
    ifid_rs_addr = 0; real_rt_addr = 0; idex_rd_addr = 0; idex_mem_read = 0;
    predicted_idex_pc = 32'h0040_0000; target_exmem_pc = 32'h0040_0000;
    cp0_intr = 0; exmem_syscall = 0; exmem_eret = 0;
  endtask

  // Check the current cycle, then advance the model's pending bit for the coming edge.
  task automatic check_cycle(input string tag);
    int row;
    #1;
    if (!rst_n) pend = 1'b0;
    row = model_row();
    check({tag, ".ctrl"}, {14'd0, ctrl_obs}, {14'd0, model_ctrl(row)});
    check({tag, ".epc"}, cu_epc, target_exmem_pc);
    check({tag, ".vector"}, cu_vector, 32'h8000_0180);
    if (rst_n) begin
      if (cp0_intr && mem_stall) pend = 1'b1;
      else if (row == 2) pend = 1'b0;
    end
  endtask

  task automatic next();
    @(negedge clk);
    set_idle();
  endtask

  initial begin
    rst_n = 0;
    set_idle();
    check_cycle("reset");
    next(); rst_n = 1;
    check_cycle("idle");

    next(); idex_mem_read = 1; idex_rd_addr = 5; ifid_rs_addr = 5;
    check_cycle("lu_rs");
    next(); idex_mem_read = 1; idex_rd_addr = 0; ifid_rs_addr = 0;
    check_cycle("lu_r0");
    next(); idex_mem_read = 1; idex_rd_addr = 4; real_rt_addr = 4; ifid_rs_addr = 1;
    check_cycle("lu_rt");
    next(); idex_rd_addr = 4; real_rt_addr = 4; ifid_rs_addr = 1;
    check_cycle("lu_noload");

    next(); predicted_idex_pc = 32'hFFFF_0000; target_exmem_pc = 32'hFFFF_0004;
    check_cycle("mispredict");
    next(); predicted_idex_pc = 32'hFFFF_0004; target_exmem_pc = 32'hFFFF_0004;
    check_cycle("predict_ok");

    next(); id_jump = 1;
    check_cycle("jump");
    next(); id_ir = 1;
    check_cycle("jr");
    next(); id_jump = 1; idex_mem_read = 1; idex_rd_addr = 7; ifid_rs_addr = 7;
    check_cycle("jump_lu");
    next(); id_ir = 1; idex_mem_read = 1; idex_rd_addr = 7; real_rt_addr = 7;
    check_cycle("jr_lu");
    next(); idex_mem_read = 1; idex_rd_addr = 7; ifid_rs_addr = 7;
    predicted_idex_pc = 32'h100; target_exmem_pc = 32'h200;
    check_cycle("mis_lu");

    next(); exmem_syscall = 1; target_exmem_pc = 32'h0040_0010;
    check_cycle("syscall");
    next(); exmem_syscall = 1; cp0_intr = 1; predicted_idex_pc = 32'h10; target_exmem_pc = 32'h14;
    check_cycle("intr_sys_mis");
    next(); exmem_eret = 1; target_exmem_pc = 32'h0040_0020;
    check_cycle("eret");

    next(); mem_stall = 1; cp0_intr = 1;
    check_cycle("stall_intr");
    next(); mem_stall = 1;
    check_cycle("stall_hold");
    next();
    check_cycle("intr_serviced");
    next();
    check_cycle("intr_once");

    next(); mem_stall = 1; cp0_intr = 1;
    check_cycle("stall_intr2");
    next(); rst_n = 0;
    check_cycle("mid_reset");
    next(); rst_n = 1;
    check_cycle("after_reset");

    for (int k = 0; k < 400; k++) begin
      next();
      mem_stall     = ($urandom_range(0, 4) == 0);
      cp0_intr      = ($urandom_range(0, 7) == 0);
      exmem_syscall = ($urandom_range(0, 7) == 0);
      exmem_eret    = ($urandom_range(0, 7) == 0);
      id_ir         = ($urandom_range(0, 3) == 0);
      id_jump       = ($urandom_range(0, 3) == 0);
      idex_mem_read = $urandom_range(0, 1);
      idex_rd_addr  = 5'($urandom_range(0, 3));
      ifid_rs_addr  = 5'($urandom_range(0, 3));
      real_rt_addr  = 5'($urandom_range(0, 3));
      predicted_idex_pc = $urandom;
      target_exmem_pc   = ($urandom_range(0, 2) == 0) ? predicted_idex_pc + 32'd4
                                                      : predicted_idex_pc;
      check_cycle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
